// File: rtl/mem_cycle_sequencer_if.sv
// Handshake/bus bundle between the control unit, the memory-cycle sequencer
// and the MAR/MDR/RAM data path.
interface mem_cycle_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 4
);
    logic              req;
    logic              rw_in;
    logic [1:0]        dl_in;
    logic [BEAT_W-1:0] beats;
    logic [ADDR_W-1:0] base_addr;
    logic              MOC;
    logic              MARld;
    logic              MDRld;
    logic              RW;
    logic              MOV;
    logic [1:0]        DL;
    logic [ADDR_W-1:0] addr_out;
    logic [BEAT_W-1:0] beat_idx;
    logic              busy;
    logic              done;
    logic              error;
    logic [2:0]        current_state;

    // Control unit / memory side
    modport master (
        output req, rw_in, dl_in, beats, base_addr, MOC,
        input  MARld, MDRld, RW, MOV, DL, addr_out, beat_idx,
               busy, done, error, current_state
    );

    // Sequencer side
    modport slave (
        input  req, rw_in, dl_in, beats, base_addr, MOC,
        output MARld, MDRld, RW, MOV, DL, addr_out, beat_idx,
               busy, done, error, current_state
    );
endinterface

// File: rtl/mem_cycle_sequencer.sv
// Memory-cycle engine: runs the MAR/MDR/MOV/MOC handshake for 1..2^BEAT_W-1
// beat transfers with size-based address stride, alignment check and MOC timeout.
module mem_cycle_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int BEAT_W  = 4,
    parameter int TIMEOUT = 15,
    parameter int TMR_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_cycle_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_NEXT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [2:0]        state;
    logic              rw_q;
    logic [1:0]        dl_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BEAT_W-1:0] rem_q;
    logic [BEAT_W-1:0] idx_q;
    logic [TMR_W-1:0]  tmr_q;

    logic [1:0]        dl_norm;
    logic [BEAT_W-1:0] beats_norm;
    logic              misaligned;
    logic [ADDR_W-1:0] stride;
    logic              bus_cycle;

    // Request decode: size 11 folds to word, zero beats folds to one
    always_comb begin
        dl_norm    = (bus.dl_in == 2'b11) ? 2'b10 : bus.dl_in;
        beats_norm = (bus.beats == '0) ? BEAT_W'(1) : bus.beats;
        misaligned = ((dl_norm == 2'b01) && bus.base_addr[0]) ||
                     ((dl_norm == 2'b10) && (bus.base_addr[1:0] != 2'b00));
        stride     = ADDR_W'(1) << dl_q;
    end

    // Sequencer state and per-transfer latches
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            rw_q   <= 1'b0;
            dl_q   <= '0;
            addr_q <= '0;
            rem_q  <= '0;
            idx_q  <= '0;
            tmr_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        rw_q   <= bus.rw_in;
                        dl_q   <= dl_norm;
                        addr_q <= bus.base_addr;
                        rem_q  <= beats_norm;
                        idx_q  <= '0;
                        state  <= misaligned ? S_ERR : S_ADDR;
                    end
                end
                S_ADDR: begin
                    tmr_q <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.MOC) begin
                        state <= S_NEXT;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                        if ((TIMEOUT != 0) && (tmr_q == TMR_LAST))
                            state <= S_ERR;
                    end
                end
                S_NEXT: begin
                    if (rem_q == BEAT_W'(1)) begin
                        state <= S_DONE;
                    end else begin
                        // Stride keeps alignment, so a wrapped address needs no recheck
                        addr_q <= addr_q + stride;
                        idx_q  <= idx_q + BEAT_W'(1);
                        rem_q  <= rem_q - BEAT_W'(1);
                        state  <= S_ADDR;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore output decode from state and latched request
    always_comb begin
        bus_cycle         = (state == S_ADDR) || (state == S_WAIT) || (state == S_NEXT);
        bus.MARld         = (state == S_ADDR);
        bus.MDRld         = ((state == S_ADDR) && !rw_q) || ((state == S_NEXT) && rw_q);
        bus.MOV           = (state == S_WAIT);
        bus.RW            = bus_cycle && rw_q;
        bus.DL            = bus_cycle ? dl_q : 2'b00;
        bus.addr_out      = addr_q;
        bus.beat_idx      = idx_q;
        bus.busy          = (state != S_IDLE);
        bus.done          = (state == S_DONE);
        bus.error         = (state == S_ERR);
        bus.current_state = state;
    end
endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Self-checking bench for mem_cycle_sequencer: scoreboard of expected beats
// and completions, plus per-scenario timing checks.
module tb_mem_cycle_sequencer;
    localparam int ADDR_W  = 32;
    localparam int BEAT_W  = 4;
    localparam int TIMEOUT = 15;
    localparam int TMR_W   = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BEAT_W-1:0] idx;
        logic              rw;
        logic [1:0]        dl;
    } beat_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   moc_delay = 0;
    int   wait_cnt  = 0;

    beat_t beat_q[$];
    bit    end_q[$];
    beat_t mon_e;
    bit    mon_end;

    mem_cycle_sequencer_if #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) bus();

    mem_cycle_sequencer #(
        .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Memory model: raise MOC after moc_delay WAIT cycles
    always @(negedge clk) begin
        if (bus.MOV) begin
            bus.MOC = (wait_cnt >= moc_delay);
            wait_cnt = wait_cnt + 1;
        end else begin
            bus.MOC = 1'b0;
            wait_cnt = 0;
        end
    end

    // Scoreboard: each MARld pops a beat, each done/error pops a completion
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.MARld) begin
                checks++;
                if (beat_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: MARld=1 addr=%h, required no beat", bus.addr_out);
                end else begin
                    mon_e = beat_q.pop_front();
                    if ({bus.addr_out, bus.beat_idx, bus.RW, bus.DL, bus.MDRld} !==
                        {mon_e.addr, mon_e.idx, mon_e.rw, mon_e.dl, ~mon_e.rw}) begin
                        errors++;
                        $display("FAIL beat: got addr=%h idx=%0d rw=%b dl=%b mdrld=%b, required addr=%h idx=%0d rw=%b dl=%b mdrld=%b",
                                 bus.addr_out, bus.beat_idx, bus.RW, bus.DL, bus.MDRld,
                                 mon_e.addr, mon_e.idx, mon_e.rw, mon_e.dl, ~mon_e.rw);
                    end
                end
            end
            if (bus.done || bus.error) begin
                checks++;
                if (end_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_end: done=%b error=%b, required none", bus.done, bus.error);
                end else begin
                    mon_end = end_q.pop_front();
                    if ({bus.done, bus.error} !== (mon_end ? 2'b10 : 2'b01)) begin
                        errors++;
                        $display("FAIL completion: got done=%b error=%b, required done=%b error=%b",
                                 bus.done, bus.error, mon_end, ~mon_end);
                    end
                end
            end
        end
    end

    function automatic beat_t mk(input logic [ADDR_W-1:0] a, input int i,
                                 input logic r, input logic [1:0] d);
        beat_t b;
        b.addr = a;
        b.idx  = BEAT_W'(i);
        b.rw   = r;
        b.dl   = d;
        return b;
    endfunction

    task automatic issue(input logic r, input logic [1:0] d,
                         input int n, input logic [ADDR_W-1:0] a);
        bus.req       = 1'b1;
        bus.rw_in     = r;
        bus.dl_in     = d;
        bus.beats     = BEAT_W'(n);
        bus.base_addr = a;
    endtask

    task automatic wait_idle(input int max_cycles, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (bus.current_state == 3'd0 && beat_q.size() == 0 && end_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        issue(1'b0, 2'b00, 0, '0);
        bus.req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.current_state, bus.MARld, bus.MDRld, bus.RW, bus.MOV, bus.DL, bus.addr_out,
             bus.beat_idx, bus.busy, bus.done, bus.error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d marld=%b mdrld=%b rw=%b mov=%b dl=%b addr=%h idx=%0d busy=%b done=%b error=%b, required all 0",
                     bus.current_state, bus.MARld, bus.MDRld, bus.RW, bus.MOV, bus.DL,
                     bus.addr_out, bus.beat_idx, bus.busy, bus.done, bus.error);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        logic [6:0] exp_vec [5];
        bit to;
        exp_vec[0] = 7'b001_1000;
        exp_vec[1] = 7'b010_0100;
        exp_vec[2] = 7'b011_0010;
        exp_vec[3] = 7'b100_0001;
        exp_vec[4] = 7'b000_0000;
        moc_delay = 0;
        beat_q.push_back(mk(32'h10, 0, 1'b1, 2'b10));
        end_q.push_back(1'b1);
        issue(1'b1, 2'b10, 1, 32'h10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) bus.req = 1'b0;
            checks++;
            if ({bus.current_state, bus.MARld, bus.MOV, bus.MDRld, bus.done} !== exp_vec[i]) begin
                errors++;
                $display("FAIL single_read_cycle%0d: state/mar/mov/mdr/done=%b, required %b",
                         i + 1, {bus.current_state, bus.MARld, bus.MOV, bus.MDRld, bus.done}, exp_vec[i]);
            end
            if (i < 3) begin
                checks++;
                if ({bus.RW, bus.DL} !== 3'b110) begin
                    errors++;
                    $display("FAIL single_read_rwdl%0d: rw=%b dl=%b, required rw=1 dl=10", i + 1, bus.RW, bus.DL);
                end
            end
        end
        wait_idle(10, to);
        checks++;
        if (to) begin errors++; $display("FAIL single_read_drain: timed out, required idle"); end
    endtask

    task automatic test_burst_write();
        int done_cyc = 0;
        int mdr_next = 0;
        bit to;
        moc_delay = 0;
        for (int k = 0; k < 4; k++) beat_q.push_back(mk(32'h20 + 32'(2 * k), k, 1'b0, 2'b01));
        end_q.push_back(1'b1);
        issue(1'b0, 2'b01, 4, 32'h20);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.req = 1'b0;
            if (bus.current_state == 3'd3 && bus.MDRld) mdr_next++;
            if (bus.done) begin done_cyc = cyc; break; end
        end
        checks++;
        if (done_cyc != 13) begin errors++; $display("FAIL burst_done_cycle: got %0d, required 13", done_cyc); end
        checks++;
        if (mdr_next != 0) begin errors++; $display("FAIL burst_mdr_in_next: got %0d, required 0", mdr_next); end
        wait_idle(10, to);
        checks++;
        if (to) begin errors++; $display("FAIL burst_drain: timed out, required idle"); end
    endtask

    task automatic test_moc_wait();
        int done_cyc = 0;
        int waits = 0;
        bit err_seen = 0;
        bit to;
        moc_delay = 3;
        beat_q.push_back(mk(32'h7, 0, 1'b1, 2'b00));
        beat_q.push_back(mk(32'h8, 1, 1'b1, 2'b00));
        end_q.push_back(1'b1);
        issue(1'b1, 2'b00, 2, 32'h7);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.req = 1'b0;
            if (bus.current_state == 3'd2) waits++;
            if (bus.error) err_seen = 1'b1;
            if (bus.done) begin done_cyc = cyc; break; end
        end
        checks++;
        if (waits != 8) begin errors++; $display("FAIL moc_wait_cycles: got %0d, required 8", waits); end
        checks++;
        if (done_cyc != 13 || err_seen) begin
            errors++;
            $display("FAIL moc_wait_done: done cycle %0d error %b, required 13 and 0", done_cyc, err_seen);
        end
        wait_idle(10, to);
        checks++;
        if (to) begin errors++; $display("FAIL moc_wait_drain: timed out, required idle"); end
        moc_delay = 0;
    endtask

    task automatic test_timeout();
        int waits = 0;
        int err_cyc = 0;
        bit done_seen = 0;
        bit mov_at_err = 1;
        moc_delay = 100000;
        beat_q.push_back(mk(32'h40, 0, 1'b1, 2'b10));
        end_q.push_back(1'b0);
        issue(1'b1, 2'b10, 1, 32'h40);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.req = 1'b0;
            if (bus.current_state == 3'd2) waits++;
            if (bus.done) done_seen = 1'b1;
            if (bus.error) begin err_cyc = cyc; mov_at_err = bus.MOV; break; end
        end
        checks++;
        if (waits != TIMEOUT || err_cyc != TIMEOUT + 2) begin
            errors++;
            $display("FAIL timeout_timing: waits=%0d error cycle=%0d, required %0d and %0d",
                     waits, err_cyc, TIMEOUT, TIMEOUT + 2);
        end
        checks++;
        if (done_seen || mov_at_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags: done=%b mov=%b, required done=0 mov=0", done_seen, mov_at_err);
        end
        @(negedge clk);
        checks++;
        if (bus.current_state !== 3'd0) begin
            errors++;
            $display("FAIL timeout_return: state=%0d, required 0", bus.current_state);
        end
        moc_delay = 0;
    endtask

    task automatic test_misaligned();
        logic [1:0]        d;
        logic [ADDR_W-1:0] a;
        logic [2:0]        st1;
        bit                strobe;
        bit                err1;
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b11;
            a = (k == 0) ? 32'h102 : (k == 1) ? 32'h101 : 32'h106;
            strobe = 1'b0;
            end_q.push_back(1'b0);
            issue(1'b1, d, 1, a);
            @(negedge clk);
            bus.req = 1'b0;
            st1 = bus.current_state;
            err1 = bus.error;
            strobe = bus.MARld | bus.MOV | bus.MDRld;
            repeat (2) begin
                @(negedge clk);
                strobe = strobe | bus.MARld | bus.MOV | bus.MDRld;
            end
            checks++;
            if (st1 !== 3'd5 || err1 !== 1'b1 || strobe || bus.current_state !== 3'd0) begin
                errors++;
                $display("FAIL misaligned_%0d: state=%0d error=%b strobes=%b final=%0d, required 5 1 0 0",
                         k, st1, err1, strobe, bus.current_state);
            end
        end
    endtask

    task automatic test_wrap();
        bit to;
        moc_delay = 0;
        beat_q.push_back(mk(32'hFFFF_FFFC, 0, 1'b0, 2'b10));
        beat_q.push_back(mk(32'h0000_0000, 1, 1'b0, 2'b10));
        end_q.push_back(1'b1);
        issue(1'b0, 2'b10, 2, 32'hFFFF_FFFC);
        @(negedge clk);
        bus.req = 1'b0;
        wait_idle(30, to);
        checks++;
        if (to) begin errors++; $display("FAIL wrap_drain: timed out, required idle"); end
    endtask

    task automatic test_reset_mid_wait();
        bit reached = 0;
        bit to;
        moc_delay = 100000;
        beat_q.push_back(mk(32'h80, 0, 1'b1, 2'b10));
        issue(1'b1, 2'b10, 1, 32'h80);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.req = 1'b0;
            if (bus.current_state == 3'd2) begin reached = 1'b1; break; end
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL reset_wait_reach: WAIT not reached, required state 2"); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.current_state, bus.MARld, bus.MDRld, bus.RW, bus.MOV, bus.DL, bus.addr_out,
             bus.beat_idx, bus.busy, bus.done, bus.error} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: state=%0d mov=%b rw=%b dl=%b addr=%h busy=%b done=%b error=%b, required all 0",
                     bus.current_state, bus.MOV, bus.RW, bus.DL, bus.addr_out, bus.busy, bus.done, bus.error);
        end
        reset = 1'b0;
        beat_q.delete();
        end_q.delete();
        moc_delay = 0;
        // Recovery request with beats=0, which must run as a single beat
        beat_q.push_back(mk(32'h44, 0, 1'b1, 2'b00));
        end_q.push_back(1'b1);
        issue(1'b1, 2'b00, 0, 32'h44);
        @(negedge clk);
        bus.req = 1'b0;
        wait_idle(20, to);
        checks++;
        if (to) begin errors++; $display("FAIL reset_recovery: timed out, required idle"); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] states = '0;
        int done_cnt = 0;
        bit to;
        moc_delay = 0;
        beat_q.push_back(mk(32'h10, 0, 1'b1, 2'b10));
        beat_q.push_back(mk(32'h30, 0, 1'b1, 2'b10));
        beat_q.push_back(mk(32'h34, 1, 1'b1, 2'b10));
        end_q.push_back(1'b1);
        end_q.push_back(1'b1);
        issue(1'b1, 2'b10, 1, 32'h10);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.base_addr = 32'h30;
                bus.dl_in     = 2'b11;
                bus.beats     = BEAT_W'(2);
            end
            if (cyc <= 6) states = {states[14:0], bus.current_state};
            if (cyc == 6) bus.req = 1'b0;
            if (bus.done) done_cnt++;
            if (done_cnt == 2) break;
        end
        checks++;
        if (states !== {3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1}) begin
            errors++;
            $display("FAIL back_to_back_states: got %b, required %b", states,
                     {3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1});
        end
        checks++;
        if (done_cnt != 2) begin errors++; $display("FAIL back_to_back_done: got %0d, required 2", done_cnt); end
        wait_idle(10, to);
        checks++;
        if (to) begin errors++; $display("FAIL back_to_back_drain: timed out, required idle"); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst_write();
        test_moc_wait();
        test_timeout();
        test_misaligned();
        test_wrap();
        test_reset_mid_wait();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_cycle_sequencer.md
Name: mem_cycle_sequencer

Overview:
- Parametrised memory-cycle engine that takes over the MAR/MDR/MOV/MOC load/store handshake from the control unit.
- Supports 1..2^BEAT_W-1 beat block transfers (LDM/STM groundwork), byte/halfword/word sizes with automatic address stride, alignment checking and a MOC timeout.
- Sits between control_unit (issues req, waits on done/error) and the MAR/MDR/RAM data path.

Parameters:
- ADDR_W, 32, width of base_addr and addr_out.
- BEAT_W, 4, width of beats and beat_idx.
- TIMEOUT, 15, max WAIT cycles with MOC low before error; 0 disables timeout.
- TMR_W, 8, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  start request; sampled only in IDLE.
- rw_in  in  1  1=read, 0=write; latched on accept.
- dl_in  in  2  data size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- beats  in  BEAT_W  beat count; 0 treated as 1.
- base_addr  in  ADDR_W  first beat address.
- MOC  in  1  memory operation complete.
- MARld  out  1  load MAR from addr_out.
- MDRld  out  1  load MDR (write: from data path; read: from memory).
- RW  out  1  latched rw toward RAM.
- MOV  out  1  memory operation valid.
- DL  out  2  latched size toward RAM (11 driven as 10).
- addr_out  out  ADDR_W  current beat address.
- beat_idx  out  BEAT_W  zero-based index of current beat.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on timeout or misalignment.
- current_state  out  3  state code, for debug and benches.

Behaviour:
- Reset: state=IDLE, all outputs 0, internal latches 0, timer 0. Reset in any state, including mid-WAIT, forces IDLE on the next edge. MOV drops that edge; no done or error is emitted.
- All outputs are Moore; they are decoded from state plus latched registers only.
- States and codes: IDLE 0, ADDR 1, WAIT 2, NEXT 3, DONE 4, ERR 5. Codes 6 and 7 are illegal and go to IDLE.
- IDLE:
  - On req=1, latch rw, dl, addr<=base_addr, and remaining beats (beats=0 becomes 1). Clear beat_idx.
  - If the address is misaligned, go to ERR; otherwise go to ADDR.
  - Misaligned means: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - req in any other state is ignored.
- ADDR (1 cycle): MARld=1. MDRld=1 if write. RW and DL driven. Timer cleared. Go to WAIT.
- WAIT: MOV=1, RW/DL held.
  - MOC=1: go to NEXT.
  - MOC=0: timer+1. If TIMEOUT!=0 and timer==TIMEOUT-1, go to ERR.
  - MOC=1 on the timeout cycle wins (go to NEXT).
- NEXT (1 cycle): MOV=0. MDRld=1 if read (capture data). Then:
  - Last beat: go to DONE.
  - Otherwise: addr<=addr+(1<<dl) with wraparound modulo 2^ADDR_W, beat_idx+1, go to ADDR. No alignment recheck after wrap, since stride preserves alignment.
- DONE: done=1 for 1 cycle, then go to IDLE.
- ERR: error=1 for 1 cycle, then go to IDLE. No MARld, MDRld or MOV is issued for a misaligned request.
- Latency:
  - A single beat with MOC already high: req sampled at edge 0; ADDR at cycle 1, WAIT 2, NEXT 3, DONE 4; back in IDLE at 5.
  - Each beat costs 3 cycles plus MOC wait cycles.
- A new req can be accepted the cycle the sequencer is back in IDLE. Back-to-back requests therefore need at least one IDLE cycle.

Test Plan:
- Single word read, base_addr=0x10, beats=1, MOC=1 -> states 0,1,2,3,4,0; MARld at cycle 1, MOV at cycle 2, MDRld at cycle 3, done pulse at cycle 4, RW=1, DL=10.
- Four-beat halfword write, base_addr=0x20 -> addr_out 0x20,0x22,0x24,0x26; MDRld in each ADDR; beat_idx 0..3; done after 12 cycles plus 1.
- Byte read, MOC held low 3 cycles per beat, beats=2 -> WAIT lasts 4 cycles per beat; addr 0x7,0x8; done; no error.
- TIMEOUT=15, MOC stuck low -> error pulse after exactly 15 WAIT cycles; MOV drops; state returns to 0; done never asserted.
- Word request at base_addr=0x102 -> ERR immediately after IDLE; error=1; MARld, MOV and MDRld never asserted. Halfword at 0x101 behaves the same.
- Word write at base_addr=0xFFFFFFFC, beats=2 -> second beat addr_out=0x00000000. Separately, assert reset during WAIT -> next edge all outputs 0, state 0, and a subsequent req works normally.
